// File: rtl/cdr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdr_pkg
// Description : Shared types and constants for the CDR phase-select sequencer:
//               FSM state encoding, phase-mux geometry and vote encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cdr_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Phase mux geometry
    localparam int NUM_PHASES = 8;
    localparam int SEL_W      = 3;

    // Vote encoding: two's-complement step of -1, 0 or +1
    localparam logic [1:0] VOTE_NONE = 2'b00;
    localparam logic [1:0] VOTE_UP   = 2'b01;
    localparam logic [1:0] VOTE_DN   = 2'b11;

    // Collapse the phase detector pair into a signed vote; contradictory or
    // absent indications carry no information and count as no vote.
    function automatic logic [1:0] decode_vote(input logic early, input logic late);
        if (late && !early) begin
            return VOTE_UP;
        end else if (early && !late) begin
            return VOTE_DN;
        end else begin
            return VOTE_NONE;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/vote_accum.sv
`default_nettype none
// ============================================================================
// Module      : vote_accum
// Description : Signed 8-bit early/late vote accumulator with symmetric
//               threshold compare. A threshold hit self-clears the count.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_accum
    import cdr_pkg::*;
#(
    parameter int THRESH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic vote_en,
    input  logic early,
    input  logic late,
    output logic hit_pos,
    output logic hit_neg
);

    localparam logic signed [7:0] c_thr_pos = 8'(THRESH);
    localparam logic signed [7:0] c_thr_neg = -c_thr_pos;

    logic signed [7:0] r_acc;
    logic signed [7:0] w_acc_nxt;
    logic        [1:0] w_vote;

    // Sign-extend the vote and form the candidate sum; a hit is only reported
    // when the vote is actually being counted.
    always_comb begin
        w_vote    = decode_vote(early, late);
        w_acc_nxt = r_acc + {{6{w_vote[1]}}, w_vote};
        hit_pos   = vote_en && (w_acc_nxt == c_thr_pos);
        hit_neg   = vote_en && (w_acc_nxt == c_thr_neg);
    end

    // Count stays within +/-(THRESH-1) because reaching either bound clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr || hit_pos || hit_neg) begin
            r_acc <= '0;
        end else if (vote_en) begin
            r_acc <= w_acc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/phase_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : phase_select_ctrl
// Description : CDR 8:1 phase-mux sequencer. Steps the registered select one
//               phase up/down (wrapping) when net votes reach THRESH, holds
//               off HOLD cycles after each step, flags lock after LOCK_CYC
//               step-free tracking cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_select_ctrl
    import cdr_pkg::*;
#(
    parameter int THRESH   = 8,
    parameter int HOLD     = 3,
    parameter int LOCK_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             early,
    input  logic             late,
    output logic [SEL_W-1:0] select,
    output logic             step_up,
    output logic             step_dn,
    output logic             locked
);

    localparam int c_hold_w = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
    localparam int c_lock_w = $clog2(LOCK_CYC + 1);

    localparam logic [c_hold_w-1:0] c_hold_top = c_hold_w'(HOLD);
    localparam logic [c_lock_w-1:0] c_lock_top = c_lock_w'(LOCK_CYC);
    // With no holdoff a step returns straight to tracking
    localparam state_t c_post_step = (HOLD == 0) ? ST_TRACK : ST_HOLD;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_select;
    logic [SEL_W-1:0]    w_select_nxt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic [c_hold_w-1:0] w_hold_inc;
    logic [c_lock_w-1:0] r_lock_cnt;
    logic [c_lock_w-1:0] w_lock_nxt;
    logic                r_step_up;
    logic                w_step_up_nxt;
    logic                r_step_dn;
    logic                w_step_dn_nxt;
    logic                r_locked;
    logic                w_locked_nxt;

    logic                w_acc_clr;
    logic                w_vote_en;
    logic                w_hit_pos;
    logic                w_hit_neg;

    // Votes count only while actively tracking; any other state discards them
    assign w_vote_en = en && (r_state == ST_TRACK);
    assign w_acc_clr = !w_vote_en;

    vote_accum #(
        .THRESH (THRESH)
    ) u_vote_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_acc_clr),
        .vote_en (w_vote_en),
        .early   (early),
        .late    (late),
        .hit_pos (w_hit_pos),
        .hit_neg (w_hit_neg)
    );

    // Next-state, select step, holdoff and lock bookkeeping
    always_comb begin
        w_state_nxt   = r_state;
        w_select_nxt  = r_select;
        w_hold_nxt    = r_hold_cnt;
        w_lock_nxt    = r_lock_cnt;
        w_step_up_nxt = 1'b0;
        w_step_dn_nxt = 1'b0;
        w_locked_nxt  = r_locked;
        w_hold_inc    = r_hold_cnt + c_hold_w'(1);

        if (!en) begin
            // Disable wins over everything, including a pending step
            w_state_nxt  = ST_IDLE;
            w_hold_nxt   = '0;
            w_lock_nxt   = '0;
            w_locked_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt  = ST_TRACK;
                    w_hold_nxt   = '0;
                    w_lock_nxt   = '0;
                    w_locked_nxt = 1'b0;
                end
                ST_TRACK: begin
                    if (w_hit_pos || w_hit_neg) begin
                        w_select_nxt  = w_hit_pos ? (r_select + SEL_W'(1))
                                                  : (r_select - SEL_W'(1));
                        w_step_up_nxt = w_hit_pos;
                        w_step_dn_nxt = w_hit_neg;
                        w_hold_nxt    = '0;
                        w_lock_nxt    = '0;
                        w_locked_nxt  = 1'b0;
                        w_state_nxt   = c_post_step;
                    end else begin
                        if (r_lock_cnt != c_lock_top) begin
                            w_lock_nxt = r_lock_cnt + c_lock_w'(1);
                        end
                        w_locked_nxt = (w_lock_nxt == c_lock_top);
                    end
                end
                ST_HOLD: begin
                    w_locked_nxt = 1'b0;
                    if (w_hold_inc == c_hold_top) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_TRACK;
                    end else begin
                        w_hold_nxt  = w_hold_inc;
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_hold_nxt   = '0;
                    w_lock_nxt   = '0;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_select   <= '0;
            r_hold_cnt <= '0;
            r_lock_cnt <= '0;
            r_step_up  <= 1'b0;
            r_step_dn  <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_select   <= w_select_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_step_up  <= w_step_up_nxt;
            r_step_dn  <= w_step_dn_nxt;
            r_locked   <= w_locked_nxt;
        end
    end

    assign select  = r_select;
    assign step_up = r_step_up;
    assign step_dn = r_step_dn;
    assign locked  = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_phase_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_select_ctrl
// Description : Self-checking bench for phase_select_ctrl. A cycle model
//               pushes expected outputs into a scoreboard queue; a monitor
//               pops and compares after every rising edge. Scenario tasks add
//               targeted inline checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_select_ctrl;
    import cdr_pkg::*;

    localparam int TH = 4;
    localparam int HO = 2;
    localparam int LC = 16;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       early;
    logic       late;
    logic [2:0] select;
    logic       step_up;
    logic       step_dn;
    logic       locked;

    int n_chk;
    int n_err;

    typedef struct {
        logic [2:0] sel;
        logic       up;
        logic       dn;
        logic       lk;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    int m_state;   // 0 idle, 1 track, 2 hold
    int m_acc;
    int m_sel;
    int m_hold;
    int m_lock;
    int m_locked;

    phase_select_ctrl #(
        .THRESH   (TH),
        .HOLD     (HO),
        .LOCK_CYC (LC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .early   (early),
        .late    (late),
        .select  (select),
        .step_up (step_up),
        .step_dn (step_dn),
        .locked  (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one edge using the currently driven inputs
    task automatic model_step();
        exp_t e;
        int   v;
        int   a;
        e.up = 1'b0;
        e.dn = 1'b0;
        if (!rst_n) begin
            m_state = 0; m_acc = 0; m_sel = 0; m_hold = 0; m_lock = 0; m_locked = 0;
        end else if (!en) begin
            m_state = 0; m_acc = 0; m_hold = 0; m_lock = 0; m_locked = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_acc = 0; m_hold = 0; m_lock = 0; m_locked = 0;
        end else if (m_state == 1) begin
            v = (late && !early) ? 1 : ((early && !late) ? -1 : 0);
            a = m_acc + v;
            if (a == TH || a == -TH) begin
                if (a == TH) begin
                    m_sel = (m_sel + 1) % 8;
                    e.up  = 1'b1;
                end else begin
                    m_sel = (m_sel + 7) % 8;
                    e.dn  = 1'b1;
                end
                m_acc = 0; m_lock = 0; m_locked = 0; m_hold = 0;
                m_state = (HO == 0) ? 1 : 2;
            end else begin
                m_acc  = a;
                m_lock = (m_lock < LC) ? m_lock + 1 : LC;
                if (m_lock == LC) m_locked = 1;
            end
        end else begin
            m_acc  = 0;
            m_hold = m_hold + 1;
            if (m_hold == HO) begin
                m_hold  = 0;
                m_state = 1;
            end
        end
        e.sel = 3'(m_sel);
        e.lk  = (m_locked != 0);
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus on the falling edge, return after the rise
    task automatic cyc(input logic r, input logic e, input logic ea, input logic la);
        @(negedge clk);
        rst_n = r;
        en    = e;
        early = ea;
        late  = la;
        model_step();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            n_chk++;
            if (select !== x.sel || step_up !== x.up || step_dn !== x.dn || locked !== x.lk) begin
                n_err++;
                $display("FAIL scoreboard t=%0t: got sel=%0d up=%b dn=%b lk=%b, expected sel=%0d up=%b dn=%b lk=%b",
                         $time, select, step_up, step_dn, locked, x.sel, x.up, x.dn, x.lk);
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, i[0], i[1], ~i[0]);
        end
        n_chk++;
        if (select !== 3'd0) begin
            n_err++; $display("FAIL reset_select: got %0d expected 0", select);
        end
        n_chk++;
        if (locked !== 1'b0) begin
            n_err++; $display("FAIL reset_locked: got %b expected 0", locked);
        end
        n_chk++;
        if (step_up !== 1'b0 || step_dn !== 1'b0) begin
            n_err++; $display("FAIL reset_steps: got up=%b dn=%b expected 0 0", step_up, step_dn);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if (dut.r_state !== ST_TRACK) begin
            n_err++; $display("FAIL reset_release_state: got %0d expected %0d", dut.r_state, ST_TRACK);
        end
    endtask

    task automatic test_step_up_wrap();
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < 4; k++) begin
                cyc(1'b1, 1'b1, 1'b0, 1'b1);
                n_chk++;
                if (step_up !== (k == 3)) begin
                    n_err++; $display("FAIL up_pulse s=%0d k=%0d: got %b expected %b", s, k, step_up, (k == 3));
                end
            end
            n_chk++;
            if (select !== 3'((s + 1) % 8)) begin
                n_err++; $display("FAIL up_select s=%0d: got %0d expected %0d", s, select, (s + 1) % 8);
            end
            for (int h = 0; h < HO; h++) begin
                cyc(1'b1, 1'b1, 1'b0, 1'b1);
                n_chk++;
                if (step_up !== 1'b0) begin
                    n_err++; $display("FAIL up_hold_pulse s=%0d h=%0d: got %b expected 0", s, h, step_up);
                end
            end
        end
    endtask

    task automatic test_step_dn_wrap();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
        end
        n_chk++;
        if (select !== 3'd7 || step_dn !== 1'b1 || step_up !== 1'b0) begin
            n_err++; $display("FAIL dn_wrap: got sel=%0d dn=%b up=%b expected sel=7 dn=1 up=0", select, step_dn, step_up);
        end
        // Late votes during holdoff must be ignored
        for (int h = 0; h < HO; h++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
            n_chk++;
            if (step_dn !== 1'b0) begin
                n_err++; $display("FAIL dn_single_pulse h=%0d: got %b expected 0", h, step_dn);
            end
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
            n_chk++;
            if (step_up !== 1'b0) begin
                n_err++; $display("FAIL dn_hold_ignored k=%0d: got up=%b expected 0", k, step_up);
            end
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        n_chk++;
        if (step_up !== 1'b1 || select !== 3'd0) begin
            n_err++; $display("FAIL dn_then_up: got up=%b sel=%0d expected up=1 sel=0", step_up, select);
        end
        for (int h = 0; h < HO; h++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_cancel_lock();
        logic ea;
        logic la;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            ea = (i % 4 == 1) || (i % 4 == 2);
            la = (i % 4 == 0) || (i % 4 == 2);
            cyc(1'b1, 1'b1, ea, la);
            n_chk++;
            if (locked !== (i + 1 >= LC) || step_up !== 1'b0 || step_dn !== 1'b0) begin
                n_err++; $display("FAIL cancel_lock i=%0d: got lk=%b up=%b dn=%b expected lk=%b up=0 dn=0",
                                  i, locked, step_up, step_dn, (i + 1 >= LC));
            end
        end
    endtask

    task automatic test_lock_loss();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
            n_chk++;
            if (locked !== (k != 3)) begin
                n_err++; $display("FAIL loss_locked k=%0d: got %b expected %b", k, locked, (k != 3));
            end
        end
        n_chk++;
        if (step_up !== 1'b1 || select !== 3'd1) begin
            n_err++; $display("FAIL loss_step: got up=%b sel=%0d expected up=1 sel=1", step_up, select);
        end
        for (int h = 0; h < HO; h++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < LC; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            n_chk++;
            if (locked !== (i == LC - 1)) begin
                n_err++; $display("FAIL relock i=%0d: got %b expected %b", i, locked, (i == LC - 1));
            end
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        // First holdoff cycle: disable
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        n_chk++;
        if (dut.r_state !== ST_IDLE || select !== 3'd2) begin
            n_err++; $display("FAIL abort_idle: got state=%0d sel=%0d expected state=%0d sel=2", dut.r_state, select, ST_IDLE);
        end
        // Build a partial count, then disable to discard it
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
            n_chk++;
            if (step_up !== 1'b0 || select !== 3'd2) begin
                n_err++; $display("FAIL abort_no_step k=%0d: got up=%b sel=%0d expected up=0 sel=2", k, step_up, select);
            end
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        n_chk++;
        if (step_up !== 1'b1 || select !== 3'd3) begin
            n_err++; $display("FAIL abort_step: got up=%b sel=%0d expected up=1 sel=3", step_up, select);
        end
    endtask

    task automatic test_random();
        logic r;
        logic e;
        logic ea;
        logic la;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 59) != 0);
            e  = ($urandom_range(0, 24) != 0);
            ea = ($urandom_range(0, 9) < ((i < 200) ? 2 : 7));
            la = ($urandom_range(0, 9) < ((i < 200) ? 7 : 2));
            cyc(r, e, ea, la);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        early  = 1'b0;
        late   = 1'b0;
        m_state = 0; m_acc = 0; m_sel = 0; m_hold = 0; m_lock = 0; m_locked = 0;

        test_reset();
        test_step_up_wrap();
        test_step_dn_wrap();
        test_cancel_lock();
        test_lock_loss();
        test_abort();
        test_random();

        @(posedge clk);
        #3;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
